execute_stage: RTL

Execute stage of the 16-bit five-stage pipeline: selects forwarded operands, performs the ALU operation, maintains the condition-code register (Z, N, C), and registers results and control into the EX/MEM pipeline register consumed by the memory stage. One result per clock when not stalled. Supports bubble insertion (flush), hold (stall) and flag restore on return-from-interrupt.

---
 rtl/execute_stage.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, condition-code register (C,N,Z)
// and the EX/MEM pipeline register feeding the memory stage.
module execute_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] imm,
    input  logic             use_imm,
    input  logic [1:0]       fwd_a_sel,
    input  logic [1:0]       fwd_b_sel,
    input  logic [WIDTH-1:0] mem_fwd_data,
    input  logic [WIDTH-1:0] wb_fwd_data,
    input  logic [WIDTH-1:0] pc,
    input  logic [2:0]       rdst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             mem_to_reg,
    input  logic             reg_write,
    input  logic             stack_op,
    input  logic             push_pop,
    input  logic             push_pc,
    input  logic             pop_pc,
    input  logic             in_op,
    input  logic             out_op,
    input  logic             flag_restore,
    input  logic [2:0]       restore_flags,
    output logic [WIDTH-1:0] ex_alu_data,
    output logic [WIDTH-1:0] ex_write_data,
    output logic [WIDTH-1:0] ex_read_add,
    output logic [WIDTH-1:0] ex_pc,
    output logic [2:0]       ex_rdst,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_reg_write,
    output logic             ex_stack_op,
    output logic             ex_push_pop,
    output logic             ex_push_pc,
    output logic             ex_pop_pc,
    output logic             ex_in_op,
    output logic             ex_out_op,
    output logic             ex_valid,
    output logic [2:0]       flags
);

    // Selects 3 and 0 both mean "use the register-file value".
    function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0]       sel,
                                                 input logic [WIDTH-1:0] reg_val,
                                                 input logic [WIDTH-1:0] mem_val,
                                                 input logic [WIDTH-1:0] wb_val);
        case (sel)
            2'd1:    fwd_mux = mem_val;
            2'd2:    fwd_mux = wb_val;
            default: fwd_mux = reg_val;
        endcase
    endfunction

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_result;
    logic [2:0]       alu_flags;
    logic [WIDTH:0]   wide;
    logic             c_next;
    logic             zn_update;
    logic [9:0]       ctl_in;
    logic [9:0]       ctl_q;
    logic             capture;

    assign ctl_in = {mem_read, mem_write, mem_to_reg, reg_write, stack_op,
                     push_pop, push_pc, pop_pc, in_op, out_op};
    assign {ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_stack_op,
            ex_push_pop, ex_push_pc, ex_pop_pc, ex_in_op, ex_out_op} = ctl_q;

    // A real instruction moves into EX/MEM only when neither flushed nor held.
    assign capture = id_valid && !flush && !stall;

    // Operand selection: forwarding per operand, immediate overrides B.
    always_comb begin
        op_a = fwd_mux(fwd_a_sel, src_a, mem_fwd_data, wb_fwd_data);
        op_b = use_imm ? imm : fwd_mux(fwd_b_sel, src_b, mem_fwd_data, wb_fwd_data);
    end

    // ALU: result plus the flag values the op would produce; the extra top bit
    // of 'wide' carries the carry/borrow or the bit shifted past the MSB.
    always_comb begin
        wide       = '0;
        alu_result = op_a;
        c_next     = flags[2];
        zn_update  = 1'b0;
        case (alu_op)
            4'd1: begin
                alu_result = ~op_a;
                zn_update  = 1'b1;
            end
            4'd2: begin
                wide       = {1'b0, op_a} + {{WIDTH{1'b0}}, 1'b1};
                alu_result = wide[WIDTH-1:0];
                c_next     = wide[WIDTH];
                zn_update  = 1'b1;
            end
            4'd3: begin
                wide       = {1'b0, op_a} - {{WIDTH{1'b0}}, 1'b1};
                alu_result = wide[WIDTH-1:0];
                c_next     = wide[WIDTH];
                zn_update  = 1'b1;
            end
            4'd4: begin
                wide       = {1'b0, op_a} + {1'b0, op_b};
                alu_result = wide[WIDTH-1:0];
                c_next     = wide[WIDTH];
                zn_update  = 1'b1;
            end
            4'd5: begin
                wide       = {1'b0, op_a} - {1'b0, op_b};
                alu_result = wide[WIDTH-1:0];
                c_next     = wide[WIDTH];
                zn_update  = 1'b1;
            end
            4'd6: begin
                alu_result = op_a & op_b;
                zn_update  = 1'b1;
            end
            4'd7: begin
                alu_result = op_a | op_b;
                zn_update  = 1'b1;
            end
            4'd8: begin
                wide       = {1'b0, op_a} << op_b[3:0];
                alu_result = wide[WIDTH-1:0];
                if (op_b[3:0] != 4'd0) c_next = wide[WIDTH];
                zn_update  = 1'b1;
            end
            4'd9: begin
                wide       = {op_a, 1'b0} >> op_b[3:0];
                alu_result = wide[WIDTH:1];
                if (op_b[3:0] != 4'd0) c_next = wide[0];
                zn_update  = 1'b1;
            end
            4'd10: alu_result = op_b;
            4'd11: c_next = 1'b1;
            4'd12: c_next = 1'b0;
            default: alu_result = op_a;
        endcase
        alu_flags = zn_update ? {c_next, alu_result[WIDTH-1], alu_result == '0}
                              : {c_next, flags[1:0]};
    end

    // Condition codes: restore wins over the ALU; only stall without flush freezes them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags <= 3'b000;
        end else if (flush || !stall) begin
            if (flag_restore)
                flags <= restore_flags;
            else if (capture)
                flags <= alu_flags;
        end
    end

    // EX/MEM register: reset > flush > stall > capture; bubbles are all-zero.
    always_ff @(posedge clk) begin
        if (!reset || flush || (!stall && !id_valid)) begin
            ex_alu_data   <= '0;
            ex_write_data <= '0;
            ex_read_add   <= '0;
            ex_pc         <= '0;
            ex_rdst       <= '0;
            ctl_q         <= '0;
            ex_valid      <= 1'b0;
        end else if (!stall) begin
            ex_alu_data   <= alu_result;
            ex_write_data <= op_a;
            ex_read_add   <= op_b;
            ex_pc         <= pc;
            ex_rdst       <= rdst;
            ctl_q         <= ctl_in;
            ex_valid      <= 1'b1;
        end
    end

endmodule
